viterbi_frame_arbiter: RTL and testbench

- Frame-granular round-robin scheduler that shares one Viterbi decode chain (input FIFO, PISO, Viterbi core, SIPO) between NUM_CH independent requesters.
- Input side: grants one channel at a time and streams exactly FRAME_WORDS 16-bit coded words from it into the chain's write port, honouring the chain's busy backpressure.
- Output side: tags each decoded byte with its originating channel using an in-order tag FIFO.
- Each coded word (8 rate-1/2 symbol pairs) yields exactly one decoded byte, so a frame returns FRAME_WORDS bytes.

---
 rtl/viterbi_frame_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_viterbi_frame_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one Viterbi decode chain between NUM_CH requesters.
// Decoded bytes are tagged with their source channel through an in-order tag FIFO of granted frames.
module viterbi_frame_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int FRAME_WORDS = 8,
    parameter int TAG_DEPTH   = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      ch_valid_i,
    input  logic [16*NUM_CH-1:0]   ch_data_i,
    output logic [NUM_CH-1:0]      ch_ready_o,
    output logic                   dvalid_o,
    output logic [15:0]            data_o,
    input  logic                   busy_i,
    input  logic                   dec_valid_i,
    input  logic [7:0]             dec_data_i,
    output logic                   out_valid_o,
    output logic [7:0]             out_data_o,
    output logic [CH_W-1:0]        out_ch_o,
    output logic                   out_last_o,
    output logic [CH_W-1:0]        active_ch_o,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int OCC_W = $clog2(TAG_DEPTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CH_W-1:0]  active_q, active_d;
    logic [CH_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic [CNT_W-1:0] byteCnt_q;

    logic [CH_W-1:0]  tagMem_q [TAG_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [OCC_W-1:0] tagCnt_q;

    logic             outValid_q, outLast_q, err_q;
    logic [7:0]       outData_q;
    logic [CH_W-1:0]  outCh_q;

    logic [CH_W-1:0]  grantSel, scanIdx;
    logic             grantFound;
    logic             streaming, xfer, lastWord, lastByte;
    logic             tagFull, tagEmpty, tagPush, tagPop;

    // Scan last+1, last+2, ... so the most recently served channel has the lowest priority.
    always_comb begin
        grantSel   = CH_W'((int'(last_q) + 1) % NUM_CH);
        grantFound = 1'b0;
        scanIdx    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            scanIdx = CH_W'((int'(last_q) + i) % NUM_CH);
            if (!grantFound && ch_valid_i[scanIdx]) begin
                grantSel   = scanIdx;
                grantFound = 1'b1;
            end
        end
    end

    assign streaming = (state_q == S_STREAM);
    assign xfer      = streaming && ch_valid_i[active_q] && !busy_i;
    assign lastWord  = (wordCnt_q == CNT_W'(FRAME_WORDS - 1));
    assign lastByte  = (byteCnt_q == CNT_W'(FRAME_WORDS - 1));
    assign tagFull   = (tagCnt_q == OCC_W'(TAG_DEPTH));
    assign tagEmpty  = (tagCnt_q == '0);
    assign tagPush   = (state_q == S_GRANT);
    assign tagPop    = dec_valid_i && !tagEmpty && lastByte;

    always_comb begin
        ch_ready_o = '0;
        if (streaming) begin
            ch_ready_o[active_q] = !busy_i;
        end
    end

    assign dvalid_o = xfer;
    assign data_o   = streaming ? ch_data_i[{active_q, 4'b0000} +: 16] : 16'h0000;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        last_d    = last_q;
        wordCnt_d = wordCnt_q;
        case (state_q)
            S_IDLE: begin
                if ((|ch_valid_i) && !tagFull) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                active_d  = grantSel;
                last_d    = grantSel;
                wordCnt_d = '0;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                if (xfer) begin
                    if (lastWord) begin
                        wordCnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        wordCnt_d = wordCnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            active_q  <= '0;
            last_q    <= CH_W'(NUM_CH - 1);
            wordCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            last_q    <= last_d;
            wordCnt_q <= wordCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tagPush) begin
            tagMem_q[wrPtr_q] <= grantSel;
        end
    end

    // A simultaneous grant push and last-byte pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            tagCnt_q <= '0;
        end else begin
            if (tagPush) begin
                wrPtr_q <= (wrPtr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (tagPop) begin
                rdPtr_q <= (rdPtr_q == PTR_W'(TAG_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
            end
            if (tagPush && !tagPop) begin
                tagCnt_q <= tagCnt_q + OCC_W'(1);
            end else if (!tagPush && tagPop) begin
                tagCnt_q <= tagCnt_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outCh_q    <= '0;
            outLast_q  <= 1'b0;
            byteCnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            if (dec_valid_i) begin
                if (!tagEmpty) begin
                    outValid_q <= 1'b1;
                    outData_q  <= dec_data_i;
                    outCh_q    <= tagMem_q[rdPtr_q];
                    outLast_q  <= lastByte;
                    byteCnt_q  <= lastByte ? '0 : byteCnt_q + CNT_W'(1);
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign out_ch_o    = outCh_q;
    assign out_last_o  = outLast_q;
    assign active_ch_o = active_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_viterbi_frame_arbiter.sv
// Self-checking bench for viterbi_frame_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run scored against a transaction-level model of frames and tags.
module tb_viterbi_frame_arbiter;

    localparam int NUM_CH      = 4;
    localparam int FRAME_WORDS = 8;
    localparam int TAG_DEPTH   = 4;

    logic                  clk;
    logic                  rst;
    logic [NUM_CH-1:0]     chValid;
    logic [16*NUM_CH-1:0]  chData;
    logic [NUM_CH-1:0]     chReady;
    logic                  dvalid;
    logic [15:0]           dataOut;
    logic                  busy;
    logic                  decValid;
    logic [7:0]            decData;
    logic                  outValid;
    logic [7:0]            outData;
    logic [1:0]            outCh;
    logic                  outLast;
    logic [1:0]            activeCh;
    logic                  err;

    viterbi_frame_arbiter #(
        .NUM_CH(NUM_CH),
        .FRAME_WORDS(FRAME_WORDS),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_valid_i(chValid),
        .ch_data_i(chData),
        .ch_ready_o(chReady),
        .dvalid_o(dvalid),
        .data_o(dataOut),
        .busy_i(busy),
        .dec_valid_i(decValid),
        .dec_data_i(decData),
        .out_valid_o(outValid),
        .out_data_o(outData),
        .out_ch_o(outCh),
        .out_last_o(outLast),
        .active_ch_o(activeCh),
        .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] valid;
        logic              decV;
        logic [7:0]        decD;
        logic              expDv;
        logic [15:0]       expData;
        logic [NUM_CH-1:0] expReady;
        logic [1:0]        expActive;
        logic              expOv;
        logic [7:0]        expOd;
        logic [1:0]        expOch;
        logic              expOl;
    } vec_t;

    typedef struct {
        int ch;
        bit last;
    } tagEnt_t;

    int          checks = 0;
    int          errors = 0;
    int          seq [NUM_CH];
    int          base [NUM_CH];
    int          expSeq [NUM_CH];
    bit          useRand = 1'b0;
    logic [15:0] randWords [NUM_CH][256];
    vec_t        vecs [21];
    tagEnt_t     expQ [$];

    // Directed words follow {ch, k+1, ch, k+1}, so channel 1 streams 0x1111, 0x1212, ...
    function automatic logic [15:0] chWord(input int c, input int k);
        logic [3:0] cn;
        logic [3:0] kn;
        if (useRand) return randWords[c][k % 256];
        cn = 4'(c);
        kn = 4'(k + 1);
        return {cn, kn, cn, kn};
    endfunction

    function automatic int rrNext(input int lastC, input logic [NUM_CH-1:0] m);
        for (int i = 1; i <= NUM_CH; i++) begin
            if (m[(lastC + i) % NUM_CH]) return (lastC + i) % NUM_CH;
        end
        return (lastC + 1) % NUM_CH;
    endfunction

    task automatic refreshData();
        for (int c = 0; c < NUM_CH; c++) chData[16*c +: 16] = chWord(c, seq[c]);
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic b, input logic dv,
                                 input logic [7:0] dd);
        chValid  = v;
        busy     = b;
        decValid = dv;
        decData  = dd;
        refreshData();
        @(negedge clk);
    endtask

    // Each source advances to its next word only when the DUT accepted the current one.
    task automatic nextCycle();
        logic [NUM_CH-1:0] hs;
        hs = chValid & chReady;
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) if (hs[c]) seq[c]++;
        refreshData();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus('0, 1'b0, 1'b0, 8'h00);
        nextCycle();
        applyStimulus('0, 1'b0, 1'b0, 8'h00);
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_dvalid"}, dvalid, 0);
        checkOutput({tag, "_ready"}, chReady, 0);
        checkOutput({tag, "_data"}, dataOut, 0);
        checkOutput({tag, "_active"}, activeCh, 0);
        checkOutput({tag, "_out_valid"}, outValid, 0);
        checkOutput({tag, "_out_data"}, outData, 0);
        checkOutput({tag, "_out_ch"}, outCh, 0);
        checkOutput({tag, "_out_last"}, outLast, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    int                n, nb, bp, tLast, tDv, fc, expCh, frameCh, lastCh, pos, idle, frames;
    bit                got, justDone, prevDec, prevLast, bsy, decV, b;
    int                prevCh;
    logic [7:0]        prevData, decD;
    logic [NUM_CH-1:0] mask, sel;
    tagEnt_t           e;

    initial begin
        rst = 1'b1;
        chValid = '0;
        chData = '0;
        busy = 1'b0;
        decValid = 1'b0;
        decData = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            seq[c] = 0;
            for (int k = 0; k < 256; k++) randWords[c][k] = 16'($urandom);
        end

        // Channel 1 sends one frame, then eight decoded bytes come back tagged with channel 1.
        for (int i = 0; i < 21; i++) begin
            vecs[i] = '{default: '0};
            vecs[i].valid     = (i <= 9) ? 4'b0010 : 4'b0000;
            vecs[i].expActive = (i >= 2) ? 2'd1 : 2'd0;
            if (i >= 2 && i <= 9) begin
                vecs[i].expDv    = 1'b1;
                vecs[i].expData  = 16'h1111 + 16'h0101 * 16'(i - 2);
                vecs[i].expReady = 4'b0010;
            end
            if (i >= 11 && i <= 18) begin
                vecs[i].decV = 1'b1;
                vecs[i].decD = 8'hA0 + 8'(i - 11);
            end
            if (i >= 12 && i <= 19) begin
                vecs[i].expOv  = 1'b1;
                vecs[i].expOd  = 8'hA0 + 8'(i - 12);
                vecs[i].expOch = 2'd1;
                vecs[i].expOl  = (i == 19);
            end
        end

        doReset();
        applyStimulus('0, 1'b0, 1'b0, 8'h00);
        checkAllZero("reset");
        nextCycle();

        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].valid, 1'b0, vecs[i].decV, vecs[i].decD);
            checkOutput("vec_dvalid", dvalid, vecs[i].expDv);
            if (vecs[i].expDv) checkOutput("vec_data", dataOut, vecs[i].expData);
            checkOutput("vec_ready", chReady, vecs[i].expReady);
            checkOutput("vec_active", activeCh, vecs[i].expActive);
            checkOutput("vec_out_valid", outValid, vecs[i].expOv);
            if (vecs[i].expOv) begin
                checkOutput("vec_out_data", outData, vecs[i].expOd);
                checkOutput("vec_out_ch", outCh, vecs[i].expOch);
                checkOutput("vec_out_last", outLast, vecs[i].expOl);
            end
            checkOutput("vec_err", err, 0);
            nextCycle();
        end

        // Fairness: all channels valid, grants 0,1,2,3 until the tag FIFO fills.
        doReset();
        for (int c = 0; c < NUM_CH; c++) base[c] = seq[c];
        n = 0;
        for (int t = 0; t < 60; t++) begin
            applyStimulus('1, 1'b0, 1'b0, 8'h00);
            if (dvalid) begin
                if (n < 32) begin
                    fc = n / 8;
                    checkOutput("fair_word", dataOut, chWord(fc, base[fc] + n % 8));
                    checkOutput("fair_active", activeCh, fc);
                end
                n++;
            end
            nextCycle();
        end
        checkOutput("fair_word_count", n, 32);
        for (int t = 0; t < 10; t++) begin
            applyStimulus('1, 1'b0, 1'b0, 8'h00);
            checkOutput("full_hold_dvalid", dvalid, 0);
            checkOutput("full_hold_ready", chReady, 0);
            nextCycle();
        end

        // One frame of decoded bytes frees a tag; the fifth grant goes back to channel 0.
        nb = 0;
        tLast = -1;
        tDv = -1;
        for (int t = 0; t < 20; t++) begin
            applyStimulus('1, 1'b0, t < 8, 8'h30 + 8'(t));
            if (outValid) begin
                checkOutput("full_out_ch", outCh, 0);
                checkOutput("full_out_last", outLast, nb == 7);
                checkOutput("full_out_data", outData, 8'h30 + 8'(nb));
                if (outLast) tLast = t;
                nb++;
            end
            if (dvalid && tDv < 0) begin
                tDv = t;
                checkOutput("fifth_grant_word", dataOut, chWord(0, base[0] + 8));
                checkOutput("fifth_grant_active", activeCh, 0);
            end
            nextCycle();
        end
        checkOutput("full_byte_count", nb, 8);
        checkOutput("fifth_grant_latency", tDv - tLast, 2);

        // Backpressure: busy for three cycles after word 4 of a channel-3 frame.
        doReset();
        base[3] = seq[3];
        n = 0;
        bp = 0;
        for (int t = 0; t < 30; t++) begin
            bsy = (bp > 0);
            applyStimulus((n < 8) ? 4'b1000 : 4'b0000, bsy, 1'b0, 8'h00);
            if (bsy) begin
                checkOutput("bp_dvalid", dvalid, 0);
                checkOutput("bp_ready", chReady, 0);
                bp--;
            end else if (dvalid) begin
                checkOutput("bp_word", dataOut, chWord(3, base[3] + n));
                n++;
                if (n == 4) bp = 3;
            end
            nextCycle();
        end
        checkOutput("bp_word_count", n, 8);

        // Reset after word 3 of a channel-2 frame, then an orphan byte, then a fresh grant.
        doReset();
        n = 0;
        for (int t = 0; t < 20 && n < 3; t++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0, 8'h00);
            if (dvalid) n++;
            nextCycle();
        end
        checkOutput("rst_pre_words", n, 3);
        rst = 1'b1;
        applyStimulus(4'b0101, 1'b0, 1'b0, 8'h00);
        nextCycle();
        applyStimulus(4'b0101, 1'b0, 1'b0, 8'h00);
        checkAllZero("midframe_reset");
        nextCycle();
        rst = 1'b0;
        applyStimulus('0, 1'b0, 1'b1, 8'h5A);
        nextCycle();
        applyStimulus('0, 1'b0, 1'b0, 8'h00);
        checkOutput("orphan_out_valid", outValid, 0);
        checkOutput("orphan_err", err, 1);
        nextCycle();
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            applyStimulus(4'b0101, 1'b0, 1'b0, 8'h00);
            checkOutput("orphan_err_sticky", err, 1);
            if (dvalid) begin
                got = 1'b1;
                checkOutput("post_reset_ready", chReady, 4'b0001);
                checkOutput("post_reset_active", activeCh, 0);
            end
            nextCycle();
        end
        checkOutput("post_reset_grant_seen", got, 1);
        doReset();
        applyStimulus('0, 1'b0, 1'b0, 8'h00);
        checkOutput("err_cleared", err, 0);
        nextCycle();

        // Randomized run: frames, round-robin order and byte tags predicted from the model.
        useRand = 1'b1;
        doReset();
        for (int c = 0; c < NUM_CH; c++) begin
            seq[c] = 0;
            expSeq[c] = 0;
        end
        expQ.delete();
        lastCh = NUM_CH - 1;
        pos = 0;
        frameCh = 0;
        frames = 0;
        idle = 0;
        justDone = 1'b0;
        prevDec = 1'b0;
        prevData = '0;
        prevCh = 0;
        prevLast = 1'b0;
        e = '{ch: 0, last: 1'b0};
        mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (justDone) begin
                justDone = 1'b0;
                if ($urandom_range(0, 2) == 0) mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            end
            decV = (expQ.size() > 0) && ($urandom_range(0, 1) == 1);
            decD = 8'($urandom);
            if (decV) e = expQ.pop_front();
            b = ($urandom_range(0, 3) == 0);
            applyStimulus(mask, b, decV, decD);

            checkOutput("rnd_out_valid", outValid, prevDec);
            if (prevDec) begin
                checkOutput("rnd_out_data", outData, prevData);
                checkOutput("rnd_out_ch", outCh, prevCh);
                checkOutput("rnd_out_last", outLast, prevLast);
            end
            prevDec = decV;
            prevData = decD;
            prevCh = e.ch;
            prevLast = e.last;
            checkOutput("rnd_err", err, 0);

            expCh = (pos == 0) ? rrNext(lastCh, mask) : frameCh;
            sel = '0;
            sel[expCh] = 1'b1;
            checkOutput("rnd_ready_channel", chReady & ~sel, 0);
            checkOutput("rnd_dvalid_handshake", dvalid, |(chReady & chValid));
            if (b) checkOutput("rnd_busy_hold", dvalid, 0);
            if (dvalid) begin
                if (pos == 0) begin
                    frameCh = expCh;
                    lastCh = expCh;
                end
                checkOutput("rnd_word", dataOut, chWord(frameCh, expSeq[frameCh]));
                expSeq[frameCh]++;
                expQ.push_back('{ch: frameCh, last: (pos == FRAME_WORDS - 1)});
                pos++;
                if (pos == FRAME_WORDS) begin
                    pos = 0;
                    frames++;
                    justDone = 1'b1;
                end
                idle = 0;
            end else begin
                idle++;
            end
            nextCycle();
            if (idle > 200) begin
                checkOutput("rnd_word_timeout", idle, 0);
                break;
            end
        end
        checkOutput("rnd_progress", frames > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired before the test finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
